accel_msg_sched_driver: RTL and testbench

//  SHA-256 message scheduler and round sequencer; upstream driver of the round compressor.
//  - Accepts one 512-bit padded block per valid/ready handshake.
//  - Expands the block into W[0..63] and steps the compressor through init, 64 rounds and

---
 rtl/accel_msg_sched_driver.sv | 177 +++++++++++++++++
 tb/tb_accel_msg_sched_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_msg_sched_driver.sv
`default_nettype none
// ============================================================================
// Module      : accel_msg_sched_driver
// Description : SHA-256 message scheduler and round sequencer. Accepts one
//               512-bit padded block per valid/ready handshake, expands it
//               into W[0..63] through a 16-word sliding window and steps the
//               downstream round compressor through CLR/INIT/64 rounds/FINAL.
// Ports       : clk, rst_n        clock, async active-low reset
//               i_blk_vld         block valid
//               i_blk_data[511:0] padded block, word 0 in [511:480]
//               i_first_blk       block starts a new message (restore IV)
//               o_blk_rdy         idle, can accept a block
//               o_w[31:0]         W[t] for current round
//               o_i[6:0]          current round index t
//               o_update_A_H      compressor loads/advances A-H
//               o_update_H0_7     compressor accumulates A-H into H0-H7
//               o_rst_hash_n      active-low: compressor restores H0-H7 to IV
//               o_is_hashing      1 = round update, 0 = load A-H from H0-H7
//               o_done            one-cycle pulse, block fully absorbed
// Revision    : 1.0 - initial release
// ============================================================================
module accel_msg_sched_driver #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_blk_vld,
    input  logic [511:0] i_blk_data,
    input  logic         i_first_blk,
    output logic         o_blk_rdy,
    output logic [31:0]  o_w,
    output logic [6:0]   o_i,
    output logic         o_update_A_H,
    output logic         o_update_H0_7,
    output logic         o_rst_hash_n,
    output logic         o_is_hashing,
    output logic         o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_win [16];
    logic [31:0] w_new_word;

    logic        r_blk_rdy, r_update_A_H, r_update_H0_7, r_rst_hash_n;
    logic        r_is_hashing, r_done;
    logic [31:0] r_w;
    logic [6:0]  r_i;

    logic        w_blk_rdy, w_update_A_H, w_update_H0_7, w_rst_hash_n;
    logic        w_is_hashing, w_done, w_load, w_shift;
    logic [31:0] w_w;
    logic [6:0]  w_i;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // r_win[j] holds W[n+j], where n is the index of the next word to be
    // issued, so the incoming word is W[n+16].
    assign w_new_word = f_s1(r_win[14]) + r_win[9] + f_s0(r_win[1]) + r_win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the state being entered so that the registered
    // strobes line up with the state they belong to.
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_blk_rdy     = 1'b0;
        w_update_A_H  = 1'b0;
        w_update_H0_7 = 1'b0;
        w_rst_hash_n  = 1'b1;
        w_is_hashing  = 1'b0;
        w_done        = 1'b0;
        w_w           = 32'd0;
        w_i           = r_i;

        case (r_state)
            S_IDLE: begin
                if (i_blk_vld) begin
                    w_load = 1'b1;
                    w_next = i_first_blk ? S_CLR : S_INIT;
                end
            end
            S_CLR:   w_next = S_INIT;
            S_INIT:  w_next = S_ROUND;
            S_ROUND: w_next = (r_i == 7'(ROUNDS - 1)) ? S_FINAL : S_ROUND;
            S_FINAL: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        case (w_next)
            S_IDLE:  w_blk_rdy     = 1'b1;
            S_CLR:   w_rst_hash_n  = 1'b0;
            S_INIT:  w_update_A_H  = 1'b1;
            S_ROUND: begin
                w_update_A_H = 1'b1;
                w_is_hashing = 1'b1;
                w_shift      = 1'b1;
                w_w          = r_win[0];
                w_i          = (r_state == S_INIT) ? 7'd0 : r_i + 7'd1;
            end
            S_FINAL: w_update_H0_7 = 1'b1;
            S_DONE:  w_done        = 1'b1;
            default: w_blk_rdy     = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_rdy     <= 1'b1;
            r_update_A_H  <= 1'b0;
            r_update_H0_7 <= 1'b0;
            r_rst_hash_n  <= 1'b1;
            r_is_hashing  <= 1'b0;
            r_done        <= 1'b0;
            r_w           <= 32'd0;
            r_i           <= 7'd0;
            for (int k = 0; k < 16; k++) begin
                r_win[k] <= 32'd0;
            end
        end else begin
            r_blk_rdy     <= w_blk_rdy;
            r_update_A_H  <= w_update_A_H;
            r_update_H0_7 <= w_update_H0_7;
            r_rst_hash_n  <= w_rst_hash_n;
            r_is_hashing  <= w_is_hashing;
            r_done        <= w_done;
            r_w           <= w_w;
            r_i           <= w_i;
            if (w_load) begin
                for (int k = 0; k < 16; k++) begin
                    r_win[k] <= i_blk_data[511 - 32*k -: 32];
                end
            end else if (w_shift) begin
                for (int k = 0; k < 15; k++) begin
                    r_win[k] <= r_win[k+1];
                end
                r_win[15] <= w_new_word;
            end
        end
    end

    assign o_blk_rdy     = r_blk_rdy;
    assign o_update_A_H  = r_update_A_H;
    assign o_update_H0_7 = r_update_H0_7;
    assign o_rst_hash_n  = r_rst_hash_n;
    assign o_is_hashing  = r_is_hashing;
    assign o_done        = r_done;
    assign o_w           = r_w;
    assign o_i           = r_i;

endmodule
`default_nettype wire

// File: tb/tb_accel_msg_sched_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_msg_sched_driver
// Description : Self-checking bench for accel_msg_sched_driver. A behavioural
//               round compressor is attached to the driver outputs; results
//               are compared against a direct SHA-256 block model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_msg_sched_driver;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_vld = 1'b0;
    logic [511:0] blk_data = '0;
    logic         first_blk = 1'b0;
    logic         blk_rdy, update_A_H, update_H0_7, rst_hash_n, is_hashing, done;
    logic [31:0]  w;
    logic [6:0]   i;

    always #5 clk = ~clk;

    accel_msg_sched_driver #(.ROUNDS(64)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_blk_vld     (blk_vld),
        .i_blk_data    (blk_data),
        .i_first_blk   (first_blk),
        .o_blk_rdy     (blk_rdy),
        .o_w           (w),
        .o_i           (i),
        .o_update_A_H  (update_A_H),
        .o_update_H0_7 (update_H0_7),
        .o_rst_hash_n  (rst_hash_n),
        .o_is_hashing  (is_hashing),
        .o_done        (done)
    );

    localparam logic [255:0] c_IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_M56_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] c_ABC   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] c_M56_1 = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 64'h8000000000000000};
    localparam logic [511:0] c_M56_2 = {448'd0, 64'd448};
    localparam logic [5:0]   c_IDLE_V = 6'b100100; // {rdy,updAH,updH,rsthn,ishash,done}

    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x); return rotr(x,7) ^ rotr(x,18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x); return rotr(x,17) ^ rotr(x,19) ^ (x >> 10); endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x); return rotr(x,2) ^ rotr(x,13) ^ rotr(x,22); endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x); return rotr(x,6) ^ rotr(x,11) ^ rotr(x,25); endfunction

    // Reference message schedule of the block under test.
    logic [31:0] ref_w [64];
    logic [31:0] obs_w [64];
    logic [255:0] ref_h = '0;

    task automatic expand(input logic [511:0] b);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = b[511 - 32*t -: 32];
            else        ref_w[t] = ss1(ref_w[t-2]) + ref_w[t-7] + ss0(ref_w[t-15]) + ref_w[t-16];
        end
    endtask

    // Direct SHA-256 block compression.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
        logic [31:0] wl [64];
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
        logic [255:0] r, o;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) wl[t] = b[511 - 32*t -: 32];
            else        wl[t] = ss1(wl[t-2]) + wl[t-7] + ss0(wl[t-15]) + wl[t-16];
        end
        {a, bb, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + bs1(e) + ((e & f) ^ (~e & g)) + K[t] + wl[t];
            t2 = bs0(a) + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = bb; bb = a; a = t1 + t2;
        end
        r = {a, bb, c, d, e, f, g, hh};
        for (int k = 0; k < 8; k++) o[255 - 32*k -: 32] = h[255 - 32*k -: 32] + r[255 - 32*k -: 32];
        return o;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural round compressor driven by the scheduler.
    logic [255:0] c_h = '0;
    logic [255:0] c_a = '0;
    always @(posedge clk) begin
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
        {a, bb, c, d, e, f, g, hh} = c_a;
        if (!rst_hash_n) c_h <= c_IV;
        if (update_A_H) begin
            if (!is_hashing) c_a <= c_h;
            else begin
                t1 = hh + bs1(e) + ((e & f) ^ (~e & g)) + K[i[5:0]] + w;
                t2 = bs0(a) + ((a & bb) ^ (a & c) ^ (bb & c));
                c_a <= {t1 + t2, a, bb, c, d + t1, e, f, g};
            end
        end
        if (update_H0_7)
            for (int k = 0; k < 8; k++) c_h[255 - 32*k -: 32] <= c_h[255 - 32*k -: 32] + c_a[255 - 32*k -: 32];
    end

    int n_done = 0;
    int n_updh = 0;
    always @(posedge clk) begin
        if (done) n_done++;
        if (update_H0_7) n_updh++;
    end

    function automatic logic [5:0] strobes();
        return {blk_rdy, update_A_H, update_H0_7, rst_hash_n, is_hashing, done};
    endfunction

    task automatic check_digest(input logic [255:0] exp);
        for (int k = 0; k < 8; k++) check("digest", 64'(c_h[255 - 32*k -: 32]), 64'(exp[255 - 32*k -: 32]));
    endtask

    time last_acc = 0;
    time this_acc = 0;

    // Called and returns on a falling edge. Issues one block and follows it
    // cycle by cycle; cycle c is the c-th clock period after the accept edge.
    task automatic run_block(input logic [511:0] b, input logic first, input logic hold);
        int off, lat, guard, t;
        logic [5:0] exp_s;
        logic seen;
        off = first ? 1 : 0;
        expand(b);
        guard = 0;
        while (!blk_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("rdy_timeout", 64'(blk_rdy), 64'd1);
            return;
        end
        blk_vld = 1'b1; blk_data = b; first_blk = first;
        @(posedge clk);
        last_acc = this_acc;
        this_acc = $time;
        ref_h = sha_compress(first ? c_IV : ref_h, b);
        seen = 1'b0; lat = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (!hold) begin
                blk_vld = 1'b0; blk_data = rand512(); first_blk = 1'($urandom);
            end
            if (c <= off)          exp_s = 6'b000000;
            else if (c == off + 1)  exp_s = 6'b010100;
            else if (c <= off + 65) exp_s = 6'b010110;
            else if (c == off + 66) exp_s = 6'b001100;
            else if (c == off + 67) exp_s = 6'b000101;
            else                    exp_s = c_IDLE_V;
            check("strobes", 64'(strobes()), 64'(exp_s));
            if (c >= off + 2 && c <= off + 65) begin
                t = c - off - 2;
                obs_w[t] = w;
                check("w", 64'(w), 64'(ref_w[t]));
                check("i", 64'(i), 64'(t));
            end else begin
                check("w_zero", 64'(w), 64'd0);
            end
            if (done) begin
                seen = 1'b1; lat = c;
            end
        end
        check("latency", 64'(lat), 64'(off + 67));
        check_digest(ref_h);
        @(negedge clk);
        check("after_done", 64'(strobes()), 64'(c_IDLE_V));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, u0, g;
        // Reset held, then released.
        repeat (3) begin
            @(negedge clk);
            check("rst_strobes", 64'(strobes()), 64'(c_IDLE_V));
            check("rst_w_i", {25'd0, i, w}, 64'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_strobes", 64'(strobes()), 64'(c_IDLE_V));
        end

        // "abc" single block.
        run_block(c_ABC, 1'b1, 1'b0);
        check_digest(c_ABC_D);
        check("abc_W0",  64'(obs_w[0]),  64'h61626380);
        check("abc_W16", 64'(obs_w[16]), 64'h61626380);
        check("abc_W17", 64'(obs_w[17]), 64'h000F0000);
        check("abc_W18", 64'(obs_w[18]), 64'h7DA86405);

        // Two-block 56-byte message.
        run_block(c_M56_1, 1'b1, 1'b0);
        run_block(c_M56_2, 1'b0, 1'b0);
        check_digest(c_M56_D);

        // blk_vld held high: back-to-back accepts.
        for (int n = 0; n < 3; n++) begin
            run_block(rand512(), 1'b1, 1'b1);
            if (n > 0) check("spacing", 64'((this_acc - last_acc) / 10), 64'd69);
        end
        blk_vld = 1'b0;
        @(negedge clk);

        // Reset pulse in the middle of round 30.
        blk_vld = 1'b1; blk_data = rand512(); first_blk = 1'b1;
        @(posedge clk);
        @(negedge clk);
        blk_vld = 1'b0;
        g = 0;
        while (!(is_hashing && i == 7'd30) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("abort_reach", 64'(i), 64'd30);
        d0 = n_done; u0 = n_updh;
        #2 rst_n = 1'b0;
        #1;
        check("abort_async", 64'(strobes()), 64'(c_IDLE_V));
        check("abort_w_i", {25'd0, i, w}, 64'd0);
        @(negedge clk);
        check("abort_hold", 64'(strobes()), 64'(c_IDLE_V));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_idle", 64'(strobes()), 64'(c_IDLE_V));
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        check("abort_no_updh", 64'(n_updh - u0), 64'd0);
        run_block(c_ABC, 1'b1, 1'b0);
        check_digest(c_ABC_D);

        // Random blocks, random message boundaries and request gaps.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_block(rand512(), (n == 0) || ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
